// File: rtl/audio_i2s_tx.sv
// Stereo I2S output stage: owns the sample-rate timebase, mixes PSG and PCM
// with signed saturation and shifts the result out as Philips I2S.
module audio_i2s_tx #(
    parameter int BCK_HALF_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] psg_left,
    input  logic [15:0] psg_right,
    input  logic [15:0] pcm_left,
    input  logic [15:0] pcm_right,
    output logic        next_sample,
    output logic        i2s_lrck,
    output logic        i2s_bck,
    output logic        i2s_data
);

    localparam int CW = 7 + BCK_HALF_LOG2;
    localparam int PW = BCK_HALF_LOG2 + 1;

    logic [CW-1:0] cnt;
    logic          ch;
    logic [4:0]    slot;
    logic          bck_d;
    logic [15:0]   hold_l;
    logic [15:0]   hold_r;
    logic [15:0]   mix_l;
    logic [15:0]   mix_r;
    logic [15:0]   word;
    logic [3:0]    bit_idx;
    logic          data_d;

    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16:15] == 2'b01)
            sat_add = 16'h7FFF;
        else if (s[16:15] == 2'b10)
            sat_add = 16'h8000;
        else
            sat_add = s[15:0];
    endfunction

    assign ch    = cnt[CW-1];
    assign slot  = cnt[CW-2 -: 5];
    assign bck_d = cnt[PW-1];
    assign mix_l = sat_add(psg_left, pcm_left);
    assign mix_r = sat_add(psg_right, pcm_right);

    // Slot 0 is the one-bit I2S delay; slots 1..16 carry the word MSB first.
    always_comb begin
        word    = ch ? hold_r : hold_l;
        bit_idx = 4'(5'd16 - slot);
        data_d  = 1'b0;
        if (slot >= 5'd1 && slot <= 5'd16)
            data_d = word[bit_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            hold_l      <= '0;
            hold_r      <= '0;
            next_sample <= 1'b0;
            i2s_lrck    <= 1'b0;
            i2s_bck     <= 1'b0;
            i2s_data    <= 1'b0;
        end else begin
            cnt         <= cnt + 1'b1;
            next_sample <= (cnt == '0);
            i2s_lrck    <= ch;
            i2s_bck     <= bck_d;
            i2s_data    <= data_d;
            // Capture coincides with right slot 31, which is padding.
            if (cnt == '1) begin
                hold_l <= mix_l;
                hold_r <= mix_r;
            end
        end
    end

endmodule
